// File: rtl/dlx_pkg.sv
// Shared DLX constants and types for the integer register file.
// Bit ordering follows the datapath: index 0 is the MSB.
package dlx_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 32;

  typedef logic [0:REG_ADDR_W-1] reg_addr_t;
  typedef logic [0:DATA_W-1]     data_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: r0 forcing, optional WB bypass, 32:1 select.
// The WB bypass is compiled in when REGFILE_WB_BYPASS_EN is defined.
module regfile_read_port
  import dlx_pkg::reg_addr_t;
  import dlx_pkg::REG_ZERO;
#(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32
) (
  input  logic [0:4]        addr,
  input  logic [0:DATA_W-1] regs [NUM_REGS],
  input  logic              we_wb,
  input  logic [0:4]        rd_wb,
  input  logic [0:DATA_W-1] wdata_wb,
  output logic [0:DATA_W-1] rdata
);

  reg_addr_t addr_r;
  assign addr_r = addr;

`ifdef REGFILE_WB_BYPASS_EN
  // addr is known non-zero on this path, so rd_wb == addr also excludes r0.
  always_comb begin
    rdata = '0;
    if (addr_r != REG_ZERO) begin
      if (we_wb && (rd_wb == addr_r)) rdata = wdata_wb;
      else                            rdata = regs[addr_r];
    end
  end
`else
  logic unused_wb;
  assign unused_wb = ^{we_wb, rd_wb, wdata_wb};

  always_comb begin
    rdata = '0;
    if (addr_r != REG_ZERO) rdata = regs[addr_r];
  end
`endif

endmodule

// File: rtl/dlx_regfile.sv
// DLX integer register file: 31 stored registers, r0 hardwired to zero, 1 write / 2 read ports.
// Define REGFILE_WB_BYPASS_EN to forward a same-cycle WB write to the ID read ports.
module dlx_regfile #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [0:dlx_pkg::REG_ADDR_W-1] rs1_id,
  input  logic [0:dlx_pkg::REG_ADDR_W-1] rs2_id,
  input  logic [0:dlx_pkg::REG_ADDR_W-1] rd_wb,
  input  logic                        we_wb,
  input  logic [0:DATA_W-1]           wdata_wb,
  output logic [0:DATA_W-1]           rdata1_id,
  output logic [0:DATA_W-1]           rdata2_id
);

  import dlx_pkg::*;

  logic [0:DATA_W-1] regs_q   [1:NUM_REGS-1];
  logic [0:DATA_W-1] reg_view [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (we_wb && (rd_wb == REG_ADDR_W'(i))) regs_q[i] <= wdata_wb;
      end
    end
  end

  // r0 has no storage; the view presents it as a constant zero entry.
  always_comb begin
    reg_view[0] = '0;
    for (int i = 1; i < NUM_REGS; i++) reg_view[i] = regs_q[i];
  end

  regfile_read_port #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W)) u_rd1 (
    .addr     (rs1_id),
    .regs     (reg_view),
    .we_wb    (we_wb),
    .rd_wb    (rd_wb),
    .wdata_wb (wdata_wb),
    .rdata    (rdata1_id)
  );

  regfile_read_port #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W)) u_rd2 (
    .addr     (rs2_id),
    .regs     (reg_view),
    .we_wb    (we_wb),
    .rd_wb    (rd_wb),
    .wdata_wb (wdata_wb),
    .rdata    (rdata2_id)
  );

endmodule

// File: tb/tb_dlx_regfile.sv
// Directed, table-driven bench for dlx_regfile (both bypass builds).
module tb_dlx_regfile;

`ifdef REGFILE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [0:4]  rs1_id, rs2_id, rd_wb;
  logic        we_wb;
  logic [0:31] wdata_wb;
  logic [0:31] rdata1_id, rdata2_id;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dlx_regfile dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rs1_id    (rs1_id),
    .rs2_id    (rs2_id),
    .rd_wb     (rd_wb),
    .we_wb     (we_wb),
    .wdata_wb  (wdata_wb),
    .rdata1_id (rdata1_id),
    .rdata2_id (rdata2_id)
  );

  // exp1/exp2 are the array contents before this row's edge; bypass is layered on in the loop.
  typedef struct {
    logic        we;
    logic [0:4]  rd;
    logic [0:31] wd;
    logic [0:4]  rs1;
    logic [0:4]  rs2;
    logic [0:31] exp1;
    logic [0:31] exp2;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [0:31] act, input logic [0:31] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [0:31] with_byp(input vec_t v, input logic [0:4] rs, input logic [0:31] arr);
    if (BYP && v.we && v.rd != 5'd0 && v.rd == rs) return v.wd;
    return arr;
  endfunction

  initial begin
    vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5, 5'd31, 32'h0,        32'h0};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,        5'd5, 5'd0,  32'hDEADBEEF, 32'h0};
    vecs[2]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0, 5'd0,  32'h0,        32'h0};
    vecs[3]  = '{1'b0, 5'd0,  32'hFFFFFFFF, 5'd0, 5'd5,  32'h0,        32'hDEADBEEF};
    vecs[4]  = '{1'b1, 5'd7,  32'h11111111, 5'd7, 5'd7,  32'h0,        32'h0};
    vecs[5]  = '{1'b1, 5'd7,  32'h22222222, 5'd7, 5'd7,  32'h11111111, 32'h11111111};
    vecs[6]  = '{1'b0, 5'd0,  32'h0,        5'd7, 5'd7,  32'h22222222, 32'h22222222};
    vecs[7]  = '{1'b1, 5'd3,  32'h03030303, 5'd3, 5'd0,  32'h0,        32'h0};
    vecs[8]  = '{1'b0, 5'd3,  32'hAAAA5555, 5'd3, 5'd3,  32'h03030303, 32'h03030303};
    vecs[9]  = '{1'b0, 5'd0,  32'h0,        5'd3, 5'd7,  32'h03030303, 32'h22222222};
    vecs[10] = '{1'b1, 5'd7,  32'h33333333, 5'd7, 5'd5,  32'h22222222, 32'hDEADBEEF};
    vecs[11] = '{1'b1, 5'd7,  32'h44444444, 5'd7, 5'd7,  32'h33333333, 32'h33333333};
    vecs[12] = '{1'b0, 5'd0,  32'h0,        5'd7, 5'd0,  32'h44444444, 32'h0};

    // Reset with no clock edge yet.
    rst_n = 1'b0; we_wb = 1'b0; rd_wb = '0; wdata_wb = '0;
    rs1_id = 5'd5; rs2_id = 5'd31;
    #1;
    check("reset_rd1", rdata1_id, 32'h0);
    check("reset_rd2", rdata2_id, 32'h0);
    #1 rst_n = 1'b1;

    foreach (vecs[k]) begin
      @(posedge clk); #1;
      we_wb = vecs[k].we; rd_wb = vecs[k].rd; wdata_wb = vecs[k].wd;
      rs1_id = vecs[k].rs1; rs2_id = vecs[k].rs2;
      #3;
      check($sformatf("vec%0d_rd1", k), rdata1_id, with_byp(vecs[k], vecs[k].rs1, vecs[k].exp1));
      check($sformatf("vec%0d_rd2", k), rdata2_id, with_byp(vecs[k], vecs[k].rs2, vecs[k].exp2));
    end

    // Async reset pulse between edges, no write pending.
    @(posedge clk); #1;
    we_wb = 1'b1; rd_wb = 5'd9; wdata_wb = 32'h12345678; rs1_id = 5'd9; rs2_id = 5'd7;
    @(posedge clk); #1;
    we_wb = 1'b0;
    #1 check("r9_written", rdata1_id, 32'h12345678);
    rst_n = 1'b0;
    #1;
    check("async_rst_r9", rdata1_id, 32'h0);
    check("async_rst_r7", rdata2_id, 32'h0);
    rst_n = 1'b1;

    // Reset held across an edge with a write pending: the write must be lost.
    @(posedge clk); #1;
    we_wb = 1'b1; rd_wb = 5'd9; wdata_wb = 32'h12345678;
    @(posedge clk); #1;
    we_wb = 1'b1; rd_wb = 5'd9; wdata_wb = 32'hCAFEF00D; rs2_id = 5'd0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    we_wb = 1'b0;
    rst_n = 1'b1;
    #1 check("rst_drops_write", rdata1_id, 32'h0);

    // Sweep r1..r31 then read every pair.
    for (int i = 1; i < 32; i++) begin
      @(posedge clk); #1;
      we_wb = 1'b1; rd_wb = 5'(i); wdata_wb = (32'(i) << 24) | 32'(i);
    end
    @(posedge clk); #1;
    we_wb = 1'b0;
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 32; j++) begin
        logic [0:31] e1, e2;
        rs1_id = 5'(i); rs2_id = 5'(j);
        #1;
        e1 = (i == 0) ? 32'h0 : ((32'(i) << 24) | 32'(i));
        e2 = (j == 0) ? 32'h0 : ((32'(j) << 24) | 32'(j));
        check($sformatf("sweep_rd1_%0d_%0d", i, j), rdata1_id, e1);
        check($sformatf("sweep_rd2_%0d_%0d", i, j), rdata2_id, e2);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dlx_regfile.md
# dlx_regfile

Integer register file for the five-stage DLX pipeline: 32 × 32-bit registers, one write port driven by the WB stage and two combinational read ports consumed by the ID stage. It is the write-side endpoint of the WB→ID dependency path: WB retires results into it, ID reads operands from it. An optional internal bypass makes a same-cycle WB write visible to ID, removing the need for a WB→ID stall.

## Interface
Parameters:
- NUM_REGS, 32, number of architectural registers; fixed at 32 because addresses are 5 bits.
- DATA_W, 32, register width.

Ports (MSB-first bit ordering, bit 0 = MSB, matching the rest of the datapath):
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rs1_id  in  [0:4]  ID-stage source register 1 address.
- rs2_id  in  [0:4]  ID-stage source register 2 address.
- rd_wb  in  [0:4]  WB-stage destination register address.
- we_wb  in  1  WB write enable.
- wdata_wb  in  [0:31]  WB write data.
- rdata1_id  out  [0:31]  operand for rs1_id, combinational.
- rdata2_id  out  [0:31]  operand for rs2_id, combinational.

## Operation
- Storage: registers r1..r31 are flops. r0 is not stored; it always reads 0.
- Write: on the rising clk edge, if we_wb=1 and rd_wb≠0, reg[rd_wb] ← wdata_wb. If rd_wb=0, the write is dropped silently.
- Read: rdataN_id = 0 if rsN_id=0; else the bypass value (see Configuration) if active; else reg[rsN_id].
- Both read ports are independent. rs1_id=rs2_id is legal and returns identical data.
- Reset: while rst_n=0, all registers are 0 immediately, with no clock required. Writes are ignored while rst_n=0. After deassertion, the first write takes effect on the first rising edge at which rst_n=1.
- No X propagation: an unwritten register reads 0.

## Timing
- Read latency 0 cycles: combinational from rsN_id and array state.
- Write latency 1 edge: data is visible through the array path in the cycle after the write edge.
- Reset value of outputs: rdata1_id = rdata2_id = 0 (all registers 0), except when the bypass is enabled and active.
- Same-cycle WB write and ID read of the same register:
  - Bypass enabled: ID sees wdata_wb in that cycle.
  - Bypass disabled: ID sees the old value; the pipeline interlock must stall ID one cycle.
- Back-to-back writes to the same register: the last edge wins.
- Reset asserted mid-cycle with a write pending: the reset dominates and the write is lost.

## Configuration
- REGFILE_WB_BYPASS_EN defined:
  - Bypass condition: we_wb=1, rd_wb≠0, rd_wb=rsN_id.
  - When the condition holds, rdataN_id = wdata_wb combinationally.
  - The ID stage needs no WB→ID stall.
- REGFILE_WB_BYPASS_EN undefined:
  - Reads come from the array only.
  - The WB→ID hazard signal must be used to stall ID for one cycle.
- Array and write behaviour are identical in both builds.

## Structure
- Shared package (dlx_pkg):
  - REG_ADDR_W = 5, DATA_W = 32, NUM_REGS = 32.
  - REG_ZERO = 5'd0.
  - Register-address and data-word typedefs.
- Sub-module regfile_read_port:
  - Instantiated twice.
  - Inputs: address, array contents, WB write signals.
  - Performs the r0 check, the bypass compare (only under REGFILE_WB_BYPASS_EN) and the 32:1 select.
- Top module holds the flop array and the write decode.

## Test plan
- Reset: assert rst_n=0 with no clock edges, rs1_id=5, rs2_id=31 -> both outputs 0; deassert, write r5=0xDEADBEEF -> next cycle rdata1_id=0xDEADBEEF.
- r0 protection: we_wb=1, rd_wb=0, wdata_wb=0xFFFFFFFF, then read rs1_id=0 -> 0 in the write cycle and every later cycle, in both builds.
- Same-cycle hazard: r7=0x11111111; then we_wb=1, rd_wb=7, wdata_wb=0x22222222, rs1_id=rs2_id=7 -> 0x22222222 with bypass, 0x11111111 without; the next cycle reads 0x22222222 in both builds.
- Write dropped by enable: we_wb=0, rd_wb=3, wdata_wb=0xAAAA5555 -> r3 stays at its prior value.
- Async reset mid-operation: r9=0x12345678, pulse rst_n low between edges -> rdata1_id(rs1_id=9) goes to 0 before the next edge.
- Sweep: write each of r1..r31 with value (i<<24)|i, then read all pairs -> exact values, with no cross-register aliasing.
